vec_alu_engine: RTL and testbench

VEC_ALU_ENGINE -- requirements
Module: vec_alu_engine

---
 rtl/vec_alu_engine_pkg.sv | 26 ++
 rtl/vec_alu_lane.sv | 37 +++
 rtl/vec_alu_engine.sv | 132 +++++++++++++
 tb/tb_vec_alu_engine.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_alu_engine_pkg.sv
// Shared opcode constants, FSM encoding and width helpers for the vector ALU engine.
// Latency: n/a (declarations only); backpressure: n/a.
package vec_alu_engine_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_SLL = 4;
  localparam int OP_SRL = 5;
  localparam int OP_SLT = 6;
  localparam int OP_XOR = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A 1-bit lane still needs a 1-bit shift field.
  function automatic int shamt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// One lane of the vector ALU: purely combinational, zero latency.
// Backpressure: none; unknown opcodes yield zero data and raise illegal.
module vec_alu_lane
  import vec_alu_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  illegal
);

  localparam int SHW = shamt_width(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (op)
      OP_WIDTH'(OP_ADD): res = a + b;
      OP_WIDTH'(OP_SUB): res = a - b;
      OP_WIDTH'(OP_AND): res = a & b;
      OP_WIDTH'(OP_OR):  res = a | b;
      OP_WIDTH'(OP_SLL): res = a << shamt;
      OP_WIDTH'(OP_SRL): res = a >> shamt;
      OP_WIDTH'(OP_SLT): res = DATA_WIDTH'($signed(a) < $signed(b));
      OP_WIDTH'(OP_XOR): res = a ^ b;
      default:           illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/vec_alu_engine.sv
// Streams len elements from base through per-lane ALUs into the result port.
// Latency: issue->write 2 cycles; no backpressure, abort drops in-flight writes.
module vec_alu_engine
  import vec_alu_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 1,
  parameter int ADDR_WIDTH = 10,
  parameter int OP_WIDTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [ADDR_WIDTH-1:0]         base_i,
  input  logic [ADDR_WIDTH:0]           len_i,
  output logic                          rd_en_o,
  output logic [ADDR_WIDTH-1:0]         rd_addr_o,
  input  logic [OP_WIDTH-1:0]           op_rdata_i,
  input  logic [LANES*DATA_WIDTH-1:0]   a_rdata_i,
  input  logic [LANES*DATA_WIDTH-1:0]   b_rdata_i,
  output logic                          res_we_o,
  output logic [ADDR_WIDTH-1:0]         res_addr_o,
  output logic [LANES*DATA_WIDTH-1:0]   res_wdata_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [ADDR_WIDTH:0]           cnt_o
);

  localparam int W = LANES * DATA_WIDTH;

  state_t                state, state_nxt;
  logic                  kill;
  logic                  accept;
  logic [ADDR_WIDTH:0]   rem;
  logic                  vld1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [W-1:0]          alu_res;
  logic [LANES-1:0]      lane_ill;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_alu_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .OP_WIDTH  (OP_WIDTH)
    ) u_lane (
      .op     (op_rdata_i),
      .a      (a_rdata_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .b      (b_rdata_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .res    (alu_res[g*DATA_WIDTH +: DATA_WIDTH]),
      .illegal(lane_ill[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    kill      = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          accept    = 1'b1;
          state_nxt = (len_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          kill      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rem == (ADDR_WIDTH+1)'(1)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The final write is on the port and nothing is left in the read stage.
        if (abort_i) begin
          kill      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (res_we_o && !vld1) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!start_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rd_en_o = (state == ST_RUN);
  assign busy_o  = (state == ST_RUN) || (state == ST_DRAIN);
  assign done_o  = (state == ST_DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_addr_o   <= '0;
      rem         <= '0;
      vld1        <= 1'b0;
      addr1       <= '0;
      res_we_o    <= 1'b0;
      res_addr_o  <= '0;
      res_wdata_o <= '0;
      cnt_o       <= '0;
      err_o       <= 1'b0;
    end else begin
      vld1     <= rd_en_o && !kill;
      addr1    <= rd_addr_o;
      res_we_o <= vld1 && !kill;
      if (vld1 && !kill) begin
        res_addr_o  <= addr1;
        res_wdata_o <= alu_res;
        if (|lane_ill) err_o <= 1'b1;
      end
      if (res_we_o) cnt_o <= cnt_o + (ADDR_WIDTH+1)'(1);
      if (accept) begin
        rd_addr_o <= base_i;
        rem       <= len_i;
        cnt_o     <= '0;
        err_o     <= 1'b0;
      end else if (rd_en_o) begin
        rd_addr_o <= rd_addr_o + ADDR_WIDTH'(1);
        rem       <= rem - (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_vec_alu_engine.sv
// Directed bench for vec_alu_engine: 1-lane instance for sequencing/ops, 4-lane for lane independence.
module tb_vec_alu_engine;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // 1-lane DUT
  logic        start, abort;
  logic [9:0]  base;
  logic [10:0] len;
  logic        rd_en, res_we, busy, done, err;
  logic [9:0]  rd_addr, res_addr;
  logic [3:0]  op_rd;
  logic [31:0] a_rd, b_rd, res_wdata;
  logic [10:0] cnt;

  vec_alu_engine #(.DATA_WIDTH(32), .LANES(1), .ADDR_WIDTH(10), .OP_WIDTH(4)) u_dut1 (
    .CLK(CLK), .RST(RST), .start_i(start), .abort_i(abort), .base_i(base), .len_i(len),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .op_rdata_i(op_rd), .a_rdata_i(a_rd), .b_rdata_i(b_rd),
    .res_we_o(res_we), .res_addr_o(res_addr), .res_wdata_o(res_wdata),
    .busy_o(busy), .done_o(done), .err_o(err), .cnt_o(cnt)
  );

  // 4-lane DUT
  logic         start4, abort4;
  logic [3:0]   base4, rd_addr4, res_addr4;
  logic [4:0]   len4, cnt4;
  logic         rd_en4, res_we4, busy4, done4, err4;
  logic [3:0]   op4_rd;
  logic [127:0] a4_rd, b4_rd, res_wdata4;

  vec_alu_engine #(.DATA_WIDTH(32), .LANES(4), .ADDR_WIDTH(4), .OP_WIDTH(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .start_i(start4), .abort_i(abort4), .base_i(base4), .len_i(len4),
    .rd_en_o(rd_en4), .rd_addr_o(rd_addr4), .op_rdata_i(op4_rd), .a_rdata_i(a4_rd), .b_rdata_i(b4_rd),
    .res_we_o(res_we4), .res_addr_o(res_addr4), .res_wdata_o(res_wdata4),
    .busy_o(busy4), .done_o(done4), .err_o(err4), .cnt_o(cnt4)
  );

  // memories with 1-cycle read latency
  logic [3:0]   op_mem [1024];
  logic [31:0]  a_mem  [1024];
  logic [31:0]  b_mem  [1024];
  logic [3:0]   op4_mem [16];
  logic [127:0] a4_mem  [16];
  logic [127:0] b4_mem  [16];

  always @(posedge CLK) begin
    if (rd_en) begin
      op_rd <= op_mem[rd_addr];
      a_rd  <= a_mem[rd_addr];
      b_rd  <= b_mem[rd_addr];
    end
    if (rd_en4) begin
      op4_rd <= op4_mem[rd_addr4];
      a4_rd  <= a4_mem[rd_addr4];
      b4_rd  <= b4_mem[rd_addr4];
    end
  end

  int ecnt = 0;
  always @(posedge CLK) ecnt++;

  // observation log, sampled mid-cycle
  int          first_rd, last_we, done_first, err_rise, rd_pulses, wr_count;
  logic [31:0] res_log [1024];
  logic [9:0]  wr_addrs [$];
  logic [127:0] res4 [16];

  always @(negedge CLK) begin
    if (rd_en) begin
      if (first_rd < 0) first_rd = ecnt;
      rd_pulses++;
    end
    if (res_we) begin
      wr_count++;
      last_we = ecnt;
      res_log[res_addr] = res_wdata;
      wr_addrs.push_back(res_addr);
    end
    if (done && done_first < 0) done_first = ecnt;
    if (err && err_rise < 0) err_rise = ecnt;
    if (res_we4) res4[res_addr4] = res_wdata4;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clr_mon();
    first_rd = -1; last_we = -1; done_first = -1; err_rise = -1;
    rd_pulses = 0; wr_count = 0;
    wr_addrs.delete();
  endtask

  task automatic run1(input int b, input int n, input int budget, output int c);
    clr_mon();
    base  = 10'(b);
    len   = 11'(n);
    start = 1'b1;
    c     = ecnt;
    for (int k = 0; k < budget && done_first < 0; k++) tick();
    chk("run_done_seen", done_first >= 0, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 1'b0);
    chk({tag, "_rd_addr"}, rd_addr, 10'd0);
    chk({tag, "_res_we"}, res_we, 1'b0);
    chk({tag, "_res_addr"}, res_addr, 10'd0);
    chk({tag, "_res_wdata"}, res_wdata, 32'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_cnt"}, cnt, 11'd0);
  endtask

  logic [31:0] exp8 [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nbad;
    logic [9:0] ea;
    exp8[0] = 32'h6;        exp8[1] = 32'hFFFF_FFFC; exp8[2] = 32'h1; exp8[3] = 32'h5;
    exp8[4] = 32'h20;       exp8[5] = 32'h0;         exp8[6] = 32'h1; exp8[7] = 32'h4;
    for (int i = 0; i < 1024; i++) begin
      op_mem[i] = 4'(i % 8);
      a_mem[i]  = 32'd1;
      b_mem[i]  = 32'd5;
    end
    op4_mem[0] = 4'd6; a4_mem[0] = {32'd8, 32'd3, 32'd2, 32'hFFFF_FFFF}; b4_mem[0] = {32'd1, 32'd1, 32'd2, 32'd0};
    op4_mem[1] = 4'd5; a4_mem[1] = {32'd8, 32'd3, 32'd2, 32'hFFFF_FFFF}; b4_mem[1] = {32'd1, 32'd1, 32'd2, 32'd1};
    op4_mem[2] = 4'd5; a4_mem[2] = {32'd8, 32'd3, 32'd2, 32'hFFFF_FFFF}; b4_mem[2] = {32'd1, 32'd1, 32'd2, 32'd0};
    start = 0; abort = 0; base = '0; len = '0;
    start4 = 0; abort4 = 0; base4 = '0; len4 = '0;
    clr_mon();

    // reset state
    repeat (3) tick();
    chk_zero("reset");
    RST = 1'b0;
    tick();

    // full sweep, all eight opcodes repeating
    run1(0, 1024, 1100, c);
    chk("t1_done_at", done_first, c + 1027);
    chk("t1_first_rd", first_rd, c + 1);
    chk("t1_last_we", last_we, c + 1026);
    chk("t1_rd_pulses", rd_pulses, 1024);
    chk("t1_wr_count", wr_count, 1024);
    chk("t1_cnt", cnt, 11'd1024);
    chk("t1_err", err, 1'b0);
    chk("t1_busy_in_done", busy, 1'b0);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_res%0d", i), res_log[i], exp8[i]);
    nbad = 0;
    for (int i = 0; i < 1024; i++) if (res_log[i] !== exp8[i % 8]) nbad++;
    chk("t1_res_all_bad", nbad, 0);
    start = 0;
    tick();
    chk("t1_idle_done", done, 1'b0);

    // wrap-around addressing
    run1(1020, 8, 40, c);
    chk("t2_done_at", done_first, c + 11);
    chk("t2_cnt", cnt, 11'd8);
    chk("t2_nwr", wr_addrs.size(), 8);
    for (int k = 0; k < 8 && k < wr_addrs.size(); k++) begin
      ea = 10'(1020 + k);
      chk($sformatf("t2_addr%0d", k), wr_addrs[k], ea);
      chk($sformatf("t2_data%0d", k), res_log[ea], exp8[ea % 8]);
    end
    start = 0;
    tick();

    // zero-length run
    run1(5, 0, 10, c);
    chk("t3_done_at", done_first, c + 1);
    repeat (3) tick();
    chk("t3_done_hold", done, 1'b1);
    chk("t3_busy", busy, 1'b0);
    start = 0;
    tick();
    chk("t3_idle_done", done, 1'b0);
    chk("t3_rd_pulses", rd_pulses, 0);
    chk("t3_wr_count", wr_count, 0);

    // illegal opcode at element 3
    op_mem[3] = 4'd9;
    run1(0, 6, 30, c);
    chk("t4_res3", res_log[3], 32'd0);
    chk("t4_res4", res_log[4], 32'h20);
    chk("t4_err_rise", err_rise, c + 6);
    chk("t4_err_done", err, 1'b1);
    start = 0;
    tick();
    chk("t4_err_idle", err, 1'b1);
    op_mem[3] = 4'd3;
    run1(8, 2, 20, c);
    chk("t4_err_cleared", err, 1'b0);
    chk("t4_err_never", err_rise, -1);
    start = 0;
    tick();

    // abort on the 5th RUN cycle
    clr_mon();
    base = 10'd100; len = 11'd20; start = 1; c = ecnt;
    tick();
    start = 0;
    repeat (4) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("t5_busy", busy, 1'b0);
    chk("t5_rd_en", rd_en, 1'b0);
    repeat (10) tick();
    chk("t5_rd_pulses", rd_pulses, 5);
    chk("t5_wr_count", wr_count, 3);
    chk("t5_cnt", cnt, 11'd3);
    chk("t5_no_done", done_first, -1);

    // reset mid-run
    clr_mon();
    base = 10'd200; len = 11'd20; start = 1; c = ecnt;
    tick();
    start = 0;
    repeat (5) tick();
    RST = 1;
    tick();
    chk_zero("t6_rst");
    RST = 0;
    repeat (10) tick();
    chk("t6_wr_count", wr_count, 4);
    chk("t6_no_done", done_first, -1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_cnt", cnt, 11'd0);

    // 4-lane SLT / SRL
    base4 = 4'd0; len4 = 5'd3; start4 = 1;
    for (int k = 0; k < 20 && !done4; k++) tick();
    chk("t7_done", done4, 1'b1);
    chk("t7_slt", res4[0], {32'd0, 32'd0, 32'd0, 32'd1});
    chk("t7_srl", res4[1], {32'd4, 32'd1, 32'd0, 32'h7FFF_FFFF});
    chk("t7_srl0", res4[2], {32'd4, 32'd1, 32'd0, 32'hFFFF_FFFF});
    chk("t7_err", err4, 1'b0);
    chk("t7_cnt", cnt4, 5'd3);
    start4 = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
